// File: rtl/decode_stage_pkg.sv
// decode_stage_pkg: shared opcode/funct constants, decoded control record and format helper
package decode_stage_pkg;
  // the immediate field is sized for the widest supported XLEN; the low XLEN bits carry the value
  localparam int IMM_W = 64;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_REG    = 7'b0110011;
  localparam logic [6:0] F7_BASE   = 7'b0000000;
  localparam logic [6:0] F7_ALT    = 7'b0100000;
  localparam logic [6:0] F7_MULDIV = 7'b0000001;
  typedef enum logic [2:0] {FMT_R, FMT_I, FMT_S, FMT_B, FMT_U, FMT_J, FMT_X} fmt_e;
  typedef struct packed {
    logic lui, auipc, jal, jalr;
    logic beq, bne, blt, bge, bltu, bgeu;
    logic lb, lh, lw, lbu, lhu, sb, sh, sw;
    logic addi, slti, sltiu, xori, ori, andi, slli, srli, srai;
    logic add, sub, sll, slt, sltu, xorr, srl, sra, orr, andr;
    logic mul, mulh, mulhsu, mulhu, div, divu, rem, remu;
  } op_flags;
  typedef struct packed {
    op_flags op;
    logic [4:0] rd;
    logic [IMM_W-1:0] imm;
  } control_info;
  function automatic fmt_e fmt_of(input logic [6:0] opc);
    return opc == OP_REG ? FMT_R :
           (opc == OP_IMM || opc == OP_LOAD || opc == OP_JALR) ? FMT_I :
           opc == OP_STORE ? FMT_S :
           opc == OP_BRANCH ? FMT_B :
           (opc == OP_LUI || opc == OP_AUIPC) ? FMT_U :
           opc == OP_JAL ? FMT_J : FMT_X;
  endfunction
endpackage

// File: rtl/decode_stage_comb.sv
// decode_comb: combinational RV32I(+M) decode of one instruction word into the control record
module decode_comb
  import decode_stage_pkg::*;
#(
  parameter int XLEN = 32,
  parameter bit EN_M = 1
) (
  input  logic [31:0]  instr,
  output control_info  ctr,
  output logic [4:0]   rs1,
  output logic [4:0]   rs2,
  output logic         illegal
);
  logic [6:0] opc, f7;
  logic [2:0] f3;
  logic br, ld, st, im, rb, ra, rm;
  op_flags op;
  fmt_e fmt;
  logic signed [31:0] raw;
  assign opc = instr[6:0];
  assign f3 = instr[14:12];
  assign f7 = instr[31:25];
  assign br = opc == OP_BRANCH;
  assign ld = opc == OP_LOAD;
  assign st = opc == OP_STORE;
  assign im = opc == OP_IMM;
  assign rb = opc == OP_REG && f7 == F7_BASE;
  assign ra = opc == OP_REG && f7 == F7_ALT;
  assign rm = EN_M && opc == OP_REG && f7 == F7_MULDIV;
  // one flag per supported opcode/funct3/funct7 combination; anything unmatched leaves all flags clear
  always_comb begin
    op = '0;
    op.lui = opc == OP_LUI;
    op.auipc = opc == OP_AUIPC;
    op.jal = opc == OP_JAL;
    op.jalr = opc == OP_JALR && f3 == 3'd0;
    op.beq = br && f3 == 3'd0;
    op.bne = br && f3 == 3'd1;
    op.blt = br && f3 == 3'd4;
    op.bge = br && f3 == 3'd5;
    op.bltu = br && f3 == 3'd6;
    op.bgeu = br && f3 == 3'd7;
    op.lb = ld && f3 == 3'd0;
    op.lh = ld && f3 == 3'd1;
    op.lw = ld && f3 == 3'd2;
    op.lbu = ld && f3 == 3'd4;
    op.lhu = ld && f3 == 3'd5;
    op.sb = st && f3 == 3'd0;
    op.sh = st && f3 == 3'd1;
    op.sw = st && f3 == 3'd2;
    op.addi = im && f3 == 3'd0;
    op.slti = im && f3 == 3'd2;
    op.sltiu = im && f3 == 3'd3;
    op.xori = im && f3 == 3'd4;
    op.ori = im && f3 == 3'd6;
    op.andi = im && f3 == 3'd7;
    op.slli = im && f3 == 3'd1 && f7 == F7_BASE;
    op.srli = im && f3 == 3'd5 && f7 == F7_BASE;
    op.srai = im && f3 == 3'd5 && f7 == F7_ALT;
    op.add = rb && f3 == 3'd0;
    op.sll = rb && f3 == 3'd1;
    op.slt = rb && f3 == 3'd2;
    op.sltu = rb && f3 == 3'd3;
    op.xorr = rb && f3 == 3'd4;
    op.srl = rb && f3 == 3'd5;
    op.orr = rb && f3 == 3'd6;
    op.andr = rb && f3 == 3'd7;
    op.sub = ra && f3 == 3'd0;
    op.sra = ra && f3 == 3'd5;
    op.mul = rm && f3 == 3'd0;
    op.mulh = rm && f3 == 3'd1;
    op.mulhsu = rm && f3 == 3'd2;
    op.mulhu = rm && f3 == 3'd3;
    op.div = rm && f3 == 3'd4;
    op.divu = rm && f3 == 3'd5;
    op.rem = rm && f3 == 3'd6;
    op.remu = rm && f3 == 3'd7;
  end
  assign illegal = ~|op;
  assign fmt = illegal ? FMT_X : fmt_of(opc);
  assign raw = fmt == FMT_I ? {{20{instr[31]}}, instr[31:20]} :
               fmt == FMT_S ? {{20{instr[31]}}, instr[31:25], instr[11:7]} :
               fmt == FMT_B ? {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0} :
               fmt == FMT_U ? {instr[31:12], 12'b0} :
               fmt == FMT_J ? {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0} : '0;
  assign ctr.op = op;
  assign ctr.rd = fmt inside {FMT_R, FMT_I, FMT_U, FMT_J} ? instr[11:7] : '0;
  assign ctr.imm = IMM_W'(XLEN'(raw));
  assign rs1 = fmt inside {FMT_R, FMT_I, FMT_S, FMT_B} ? instr[19:15] : '0;
  assign rs2 = fmt inside {FMT_R, FMT_S, FMT_B} ? instr[24:20] : '0;
endmodule

// File: rtl/decode_stage.sv
// decode_stage: decodes incoming instructions and buffers the records in a small skid queue
module decode_stage
  import decode_stage_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter bit EN_M  = 1,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_instr,
  input  logic [XLEN-1:0]  in_pc,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output control_info      out_ctr,
  output logic [4:0]       out_rs1,
  output logic [4:0]       out_rs2,
  output logic [XLEN-1:0]  out_pc,
  output logic             out_illegal
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  typedef struct packed {
    control_info ctr;
    logic [4:0] rs1, rs2;
    logic [XLEN-1:0] pc;
    logic illegal;
  } entry_t;
  entry_t q [DEPTH];
  entry_t d, h;
  control_info dc_ctr;
  logic [4:0] dc_rs1, dc_rs2;
  logic dc_ill, push, pop;
  logic [AW-1:0] rp, wp;
  logic [CW-1:0] cnt;
  decode_comb #(.XLEN(XLEN), .EN_M(EN_M)) u_dec (
    .instr(in_instr), .ctr(dc_ctr), .rs1(dc_rs1), .rs2(dc_rs2), .illegal(dc_ill)
  );
  assign d = {dc_ctr, dc_rs1, dc_rs2, in_pc, dc_ill};
  assign h = q[rp];
  assign in_ready = cnt < CW'(DEPTH);
  assign out_valid = cnt != '0;
  assign push = in_valid & in_ready & ~flush;
  assign pop = out_valid & out_ready;
  assign out_ctr = out_valid ? h.ctr : '0;
  assign out_rs1 = out_valid ? h.rs1 : '0;
  assign out_rs2 = out_valid ? h.rs2 : '0;
  assign out_pc = out_valid ? h.pc : '0;
  assign out_illegal = out_valid & h.illegal;
  // queue storage: write the decoded record at the tail on every accepted push
  always_ff @(posedge clk)
    if (push) q[wp] <= d;
  // pointers and occupancy; reset and flush empty the queue, flush overriding push/pop
  always_ff @(posedge clk)
    if (!rstn || flush) begin
      cnt <= '0;
      rp <= '0;
      wp <= '0;
    end else begin
      if (push) wp <= wp + 1'b1;
      if (pop) rp <= rp + 1'b1;
      cnt <= push && !pop ? cnt + 1'b1 : pop && !push ? cnt - 1'b1 : cnt;
    end
endmodule

// File: tb/tb_decode_stage.sv
// tb_decode_stage: directed self-checking bench for decode_stage with M enabled and disabled
module tb_decode_stage;
  import decode_stage_pkg::*;
  logic clk = 1'b0;
  logic rstn, in_valid, flush, out_ready;
  logic [31:0] in_instr, in_pc;
  logic in_ready, out_valid, out_illegal;
  logic nm_in_ready, nm_out_valid, nm_out_illegal;
  control_info out_ctr, nm_out_ctr;
  logic [4:0] out_rs1, out_rs2, nm_rs1, nm_rs2;
  logic [31:0] out_pc, nm_pc;
  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  decode_stage #(.XLEN(32), .EN_M(1), .DEPTH(2)) dut (
    .clk(clk), .rstn(rstn), .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr),
    .in_pc(in_pc), .flush(flush), .out_valid(out_valid), .out_ready(out_ready), .out_ctr(out_ctr),
    .out_rs1(out_rs1), .out_rs2(out_rs2), .out_pc(out_pc), .out_illegal(out_illegal)
  );

  decode_stage #(.XLEN(32), .EN_M(0), .DEPTH(2)) dut_nm (
    .clk(clk), .rstn(rstn), .in_valid(in_valid), .in_ready(nm_in_ready), .in_instr(in_instr),
    .in_pc(in_pc), .flush(flush), .out_valid(nm_out_valid), .out_ready(out_ready), .out_ctr(nm_out_ctr),
    .out_rs1(nm_rs1), .out_rs2(nm_rs2), .out_pc(nm_pc), .out_illegal(nm_out_illegal)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rstn = 0; in_valid = 0; in_instr = 0; in_pc = 0; flush = 0; out_ready = 0;
    tick; tick;
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_in_ready", 64'(in_ready), 64'd1);
    check("rst_ctr_zero", 64'(|out_ctr), 64'd0);
    check("rst_pc_zero", 64'(out_pc), 64'd0);
    check("rst_illegal", 64'(out_illegal), 64'd0);
    check("rst_rs", 64'({out_rs1, out_rs2}), 64'd0);

    // addi x1,x2,-1
    rstn = 1; in_valid = 1; in_instr = 32'hFFF10093; in_pc = 32'h100; out_ready = 1;
    tick;
    in_valid = 0;
    check("addi_valid", 64'(out_valid), 64'd1);
    check("addi_flag", 64'(out_ctr.op.addi), 64'd1);
    check("addi_onehot", 64'($countones(out_ctr.op)), 64'd1);
    check("addi_rd", 64'(out_ctr.rd), 64'd1);
    check("addi_rs1", 64'(out_rs1), 64'd2);
    check("addi_rs2", 64'(out_rs2), 64'd0);
    check("addi_imm", 64'(out_ctr.imm[31:0]), 64'hFFFFFFFF);
    check("addi_pc", 64'(out_pc), 64'h100);
    check("addi_illegal", 64'(out_illegal), 64'd0);
    tick;
    check("addi_popped", 64'(out_valid), 64'd0);

    // backpressure: lui, add, sub with the consumer stalled
    out_ready = 0; in_valid = 1; in_instr = 32'h123452B7; in_pc = 32'h200;
    tick;
    in_instr = 32'h002081B3; in_pc = 32'h204;
    tick;
    check("bp_full_ready", 64'(in_ready), 64'd0);
    check("bp_head_lui", 64'(out_ctr.op.lui), 64'd1);
    check("bp_head_pc", 64'(out_pc), 64'h200);
    check("bp_lui_imm", 64'(out_ctr.imm[31:0]), 64'h12345000);
    check("bp_lui_rs1", 64'(out_rs1), 64'd0);
    in_instr = 32'h40118233; in_pc = 32'h208;
    tick;
    check("bp_still_full", 64'(in_ready), 64'd0);
    check("bp_head_hold", 64'(out_pc), 64'h200);
    out_ready = 1;
    tick;
    check("bp_head_add", 64'(out_ctr.op.add), 64'd1);
    check("bp_add_pc", 64'(out_pc), 64'h204);
    check("bp_add_rs", 64'({out_rs1, out_rs2, out_ctr.rd}), 64'({5'd1, 5'd2, 5'd3}));
    check("bp_ready_after_pop", 64'(in_ready), 64'd1);
    tick;
    in_valid = 0;
    check("bp_head_sub", 64'(out_ctr.op.sub), 64'd1);
    check("bp_sub_pc", 64'(out_pc), 64'h208);
    check("bp_sub_rs", 64'({out_rs1, out_rs2, out_ctr.rd}), 64'({5'd3, 5'd1, 5'd4}));
    tick;
    check("bp_drained", 64'(out_valid), 64'd0);

    // streaming push+pop every cycle with one entry resident
    in_valid = 1; in_instr = 32'h00000093; in_pc = 32'h1000;
    tick;
    for (int k = 0; k < 16; k++) begin
      check("str_valid", 64'(out_valid), 64'd1);
      check("str_ready", 64'(in_ready), 64'd1);
      check("str_pc", 64'(out_pc), 64'(32'h1000 + 4 * k));
      check("str_imm", 64'(out_ctr.imm[31:0]), 64'(k));
      in_instr = {12'(k + 1), 20'h00093}; in_pc = 32'h1000 + 4 * (k + 1);
      tick;
    end
    in_valid = 0;
    check("str_last_pc", 64'(out_pc), 64'h1040);
    check("str_last_imm", 64'(out_ctr.imm[31:0]), 64'd16);
    tick;
    check("str_drained", 64'(out_valid), 64'd0);

    // mul x3,x1,x2 on both configurations
    in_valid = 1; in_instr = 32'h022081B3; in_pc = 32'h300;
    tick;
    in_valid = 0;
    check("mul_flag", 64'(out_ctr.op.mul), 64'd1);
    check("mul_onehot", 64'($countones(out_ctr.op)), 64'd1);
    check("mul_rd", 64'(out_ctr.rd), 64'd3);
    check("mul_legal", 64'(out_illegal), 64'd0);
    check("nm_mul_valid", 64'(nm_out_valid), 64'd1);
    check("nm_mul_illegal", 64'(nm_out_illegal), 64'd1);
    check("nm_mul_flags", 64'(|nm_out_ctr.op), 64'd0);
    check("nm_mul_rd", 64'(nm_out_ctr.rd), 64'd0);
    check("nm_mul_imm", 64'(nm_out_ctr.imm[31:0]), 64'd0);
    check("nm_mul_pc", 64'(nm_pc), 64'h300);
    tick;

    // flush with a full queue and a pending instruction
    out_ready = 0; in_valid = 1; in_instr = 32'h00100093; in_pc = 32'h2000;
    tick;
    in_instr = 32'h00200093; in_pc = 32'h2004;
    tick;
    check("fl_full", 64'(in_ready), 64'd0);
    flush = 1; in_instr = 32'h7FF00093; in_pc = 32'h3000;
    tick;
    flush = 0; in_valid = 0;
    check("fl_valid", 64'(out_valid), 64'd0);
    check("fl_ready", 64'(in_ready), 64'd1);
    check("fl_nm_valid", 64'(nm_out_valid), 64'd0);
    out_ready = 1;
    tick;
    check("fl_no_emit", 64'(out_valid), 64'd0);

    // flush with one entry resident and a push offered while ready
    out_ready = 0; in_valid = 1; in_instr = 32'h00100093; in_pc = 32'h2100;
    tick;
    flush = 1; in_instr = 32'h00300093; in_pc = 32'h2104;
    tick;
    flush = 0; in_valid = 0; out_ready = 1;
    check("fl1_valid", 64'(out_valid), 64'd0);
    tick;
    check("fl1_no_emit", 64'(out_valid), 64'd0);

    // beq -4, jalr funct3=1, srai x5,x5,3 back to back
    in_valid = 1; in_instr = 32'hFE000EE3; in_pc = 32'h400;
    tick;
    check("beq_flag", 64'(out_ctr.op.beq), 64'd1);
    check("beq_imm", 64'(out_ctr.imm[31:0]), 64'hFFFFFFFC);
    check("beq_rd", 64'(out_ctr.rd), 64'd0);
    check("beq_pc", 64'(out_pc), 64'h400);
    in_instr = 32'h000110E7; in_pc = 32'h404;
    tick;
    check("jalr_f3_illegal", 64'(out_illegal), 64'd1);
    check("jalr_f3_flags", 64'(|out_ctr.op), 64'd0);
    check("jalr_f3_rd", 64'(out_ctr.rd), 64'd0);
    in_instr = 32'h4032D293; in_pc = 32'h408;
    tick;
    in_valid = 0;
    check("srai_flag", 64'(out_ctr.op.srai), 64'd1);
    check("srai_onehot", 64'($countones(out_ctr.op)), 64'd1);
    check("srai_imm", 64'(out_ctr.imm[11:0]), 64'h403);
    check("srai_rd_rs1", 64'({out_ctr.rd, out_rs1, out_rs2}), 64'({5'd5, 5'd5, 5'd0}));
    tick;
    check("br_drained", 64'(out_valid), 64'd0);

    // reset mid-operation with a pending input
    out_ready = 0; in_valid = 1; in_instr = 32'h00100093; in_pc = 32'h500;
    tick;
    check("mr_pre_valid", 64'(out_valid), 64'd1);
    rstn = 0; in_pc = 32'h504;
    tick;
    rstn = 1; in_valid = 0;
    check("mr_valid", 64'(out_valid), 64'd0);
    check("mr_ready", 64'(in_ready), 64'd1);
    tick;
    check("mr_still_empty", 64'(out_valid), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/decode_stage.md
Name: decode_stage

Overview:
- Parametrised successor of the single-register instruction decoder.
- Decodes RV32I, plus RV32M when enabled, into the shared control_info record.
- Adds valid/ready handshakes on both sides, a 2-entry skid queue, flush, illegal-instruction detection and a carried PC.
- Sits between the fetch stage and the register-read/execute stage.

Parameters:
- XLEN, 32, datapath width for immediate and PC (32 or 64); the immediate is sign-extended to XLEN.
- EN_M, 1, when 1 the M-extension ops decode; when 0 they are flagged illegal.
- DEPTH, 2, skid queue entries (power of two, at least 2).

Ports:
- CLK  in  1  clock
- RSTN  in  1  synchronous active-low reset
- IN_VALID  in  1  fetch offers an instruction
- IN_READY  out  1  stage can accept
- IN_INSTR  in  32  raw instruction word
- IN_PC  in  XLEN  PC of IN_INSTR
- FLUSH  in  1  discard all queued and incoming instructions
- OUT_VALID  out  1  head entry valid
- OUT_READY  in  1  downstream consumes head
- OUT_CTR  out  control_info  decoded one-hot op flags, rd, immediate
- OUT_RS1  out  5  rs1 of head; 0 if the format has no rs1
- OUT_RS2  out  5  rs2 of head; 0 if the format has no rs2
- OUT_PC  out  XLEN  PC of head
- OUT_ILLEGAL  out  1  head is not a supported instruction

Behaviour:
- Clock and reset: one clock; reset is synchronous and active-low on RSTN. At reset: count=0, rd/wr pointers=0, OUT_VALID=0, IN_READY=1. OUT_CTR, OUT_RS1/RS2, OUT_PC and OUT_ILLEGAL read as all-zero while OUT_VALID=0.
- Push/pop:
  - push = IN_VALID & IN_READY & ~FLUSH
  - pop = OUT_VALID & OUT_READY
  - IN_READY = (count < DEPTH), combinational from count only.
- Decode happens combinationally on IN_INSTR before the push. The queue stores the decoded record: ctr, rs1, rs2, pc, illegal.
- Latency: an instruction accepted at cycle N appears at the head with OUT_VALID=1 at N+1 when the queue was empty. No combinational IN→OUT path.
- Simultaneous push and pop: count unchanged, both pointers advance.
  - Full: IN_READY=0, so no push; a pop frees a slot next cycle.
  - Empty: a pop is impossible.
  - Pointers wrap modulo DEPTH.
- FLUSH: next cycle count=0 and OUT_VALID=0. A same-cycle push is dropped. A same-cycle pop is still a valid handshake downstream but its effect is overridden. FLUSH has priority over push and pop.
- Field extraction:
  - RS1 is non-zero only for R/I/S/B formats; RS2 only for R/S/B; rd only for R/I/U/J. Otherwise the field is 0.
  - funct3 and funct7 use their full 3/7-bit widths.
  - Shift-immediates compare instr[31:25] against 0000000 or 0100000.
- Immediate formats, each sign-extended from instr[31] to XLEN:
  - I = instr[31:20]
  - S = {instr[31:25], instr[11:7]}
  - B = {instr[31], instr[7], instr[30:25], instr[11:8], 0}
  - U = {instr[31:12], 12'b0}
  - J = {instr[31], instr[19:12], instr[20], instr[30:21], 0}
- Illegal: any opcode/funct3/funct7 combination outside the supported list, including jalr with funct3≠0 and M ops when EN_M=0. Illegal entries are still queued with OUT_ILLEGAL=1, all op flags 0, rd=0, imm=0.
- Exactly one op flag is set for every legal entry.
- Reset mid-operation drops all entries; pending inputs are not accepted during the reset cycle.

Decomposition:
- Shared package (def):
  - control_info struct, with immediate widened to XLEN.
  - Opcode constants: OP_LUI, OP_AUIPC, OP_JAL, OP_JALR, OP_BRANCH, OP_LOAD, OP_STORE, OP_IMM, OP_REG.
  - funct7 constants: F7_BASE, F7_ALT, F7_MULDIV.
- Sub-module decode_comb: purely combinational instruction → {ctr, rs1, rs2, illegal}, parametrised by XLEN and EN_M.
- decode_stage owns the queue, pointers, count and handshake.

Test Plan:
- Reset, then push addi x1,x2,-1 (0xFFF10093) with OUT_READY=1 → next cycle OUT_VALID=1, addi=1, rd=1, OUT_RS1=2, OUT_RS2=0, imm=0xFFFFFFFF, PC matches.
- Hold OUT_READY=0 and push 3 instructions → IN_READY drops after 2; release OUT_READY → entries drain in order; the third is accepted one cycle after the first pop.
- Every cycle push and pop with count=1 → count stays 1, throughput 1/cycle over 16 instructions, order preserved through pointer wrap.
- EN_M=0 with mul x3,x1,x2 (0x022081B3) → OUT_ILLEGAL=1 with all flags 0. EN_M=1 with the same word → mul=1, rd=3.
- Queue full, assert FLUSH together with IN_VALID → next cycle OUT_VALID=0, count 0, the flushed-cycle instruction is never emitted.
- Branch encodings: beq with offset -4 (0xFE000EE3) → imm=0xFFFFFFFC, rd=0. jalr with funct3=1 → illegal. srai x5,x5,3 (0x4032D293) → srai=1, imm low bits=0x403.
